// File: rtl/ac97_cmd_sched.sv
// rtl/ac97_cmd_sched.sv - AC97 codec register command scheduler with init sequence and read tracking
module ac97_cmd_sched #(
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic        ac97_bitclk,
    input  logic        rst,
    input  logic        ac97_strobe,
    input  logic [19:0] ac97_in_slot1,
    input  logic        ac97_in_slot1_valid,
    input  logic [19:0] ac97_in_slot2,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [23:0] req_cmd0,
    input  logic [23:0] req_cmd1,
    output logic [19:0] ac97_out_slot1,
    output logic        ac97_out_slot1_valid,
    output logic [19:0] ac97_out_slot2,
    output logic        ac97_out_slot2_valid,
    output logic        rsp_valid,
    output logic        rsp_src,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        init_done
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT_RD
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_FRAMES - 1);

    state_t      state_q, state_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic [3:0]  tmo_cnt_q, tmo_cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [6:0]  rd_addr_q, rd_addr_d;
    logic        rd_src_q, rd_src_d;
    logic [19:0] slot1_q, slot1_d;
    logic [19:0] slot2_q, slot2_d;
    logic        slot_valid_q, slot_valid_d;
    logic        init_done_q, init_done_d;

    logic        grant;
    logic [23:0] cmd;
    logic        hit;
    logic [22:0] init_entry;
    logic [1:0]  ready_c;
    logic        rsp_valid_c;
    logic        rsp_timeout_c;
    logic [15:0] rsp_data_c;
    logic        rsp_src_c;

    // Reply bits outside the address field carry nothing this block needs.
    logic unused_bits;
    assign unused_bits = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

    // Codec power-up register writes, {addr, data}, issued one per frame.
    function automatic logic [22:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = {7'h00, 16'h0000};
            3'd1:    init_cmd = {7'h02, 16'h0000};
            3'd2:    init_cmd = {7'h04, 16'h1F1F};
            default: init_cmd = {7'h18, 16'h0808};
        endcase
    endfunction

    // Frame-level scheduling: everything below only advances on a strobe.
    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        tmo_cnt_d     = tmo_cnt_q;
        last_grant_d  = last_grant_q;
        rd_addr_d     = rd_addr_q;
        rd_src_d      = rd_src_q;
        slot1_d       = slot1_q;
        slot2_d       = slot2_q;
        slot_valid_d  = slot_valid_q;
        init_done_d   = init_done_q;
        ready_c       = 2'b00;
        rsp_valid_c   = 1'b0;
        rsp_timeout_c = 1'b0;
        rsp_data_c    = 16'h0000;
        rsp_src_c     = 1'b0;

        // Round-robin: on contention the requester not granted last wins.
        grant      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        cmd        = grant ? req_cmd1 : req_cmd0;
        hit        = ac97_in_slot1_valid && (ac97_in_slot1[18:12] == rd_addr_q);
        init_entry = init_cmd(init_idx_q);

        if (ac97_strobe) begin
            // A frame carries a command only when one is explicitly loaded.
            slot1_d      = 20'h00000;
            slot2_d      = 20'h00000;
            slot_valid_d = 1'b0;
            unique case (state_q)
                ST_INIT: begin
                    if (init_idx_q == 3'd4) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        slot1_d      = {1'b0, init_entry[22:16], 12'h000};
                        slot2_d      = {init_entry[15:0], 4'h0};
                        slot_valid_d = 1'b1;
                        init_idx_d   = init_idx_q + 3'd1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        ready_c      = grant ? 2'b10 : 2'b01;
                        last_grant_d = grant;
                        slot1_d      = {cmd[23], cmd[22:16], 12'h000};
                        slot2_d      = cmd[23] ? 20'h00000 : {cmd[15:0], 4'h0};
                        slot_valid_d = 1'b1;
                        if (cmd[23]) begin
                            state_d   = ST_WAIT_RD;
                            rd_addr_d = cmd[22:16];
                            rd_src_d  = grant;
                            tmo_cnt_d = 4'd0;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (hit) begin
                        rsp_valid_c = 1'b1;
                        rsp_data_c  = ac97_in_slot2[19:4];
                        rsp_src_c   = rd_src_q;
                        state_d     = ST_IDLE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rsp_valid_c   = 1'b1;
                        rsp_timeout_c = 1'b1;
                        rsp_data_c    = 16'hFFFF;
                        rsp_src_c     = rd_src_q;
                        state_d       = ST_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 4'd1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // State register; reset restarts the init sequence and drops any pending read.
    always_ff @(posedge ac97_bitclk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_idx_q   <= 3'd0;
            tmo_cnt_q    <= 4'd0;
            last_grant_q <= 1'b1;
            rd_addr_q    <= 7'h00;
            rd_src_q     <= 1'b0;
            slot1_q      <= 20'h00000;
            slot2_q      <= 20'h00000;
            slot_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            last_grant_q <= last_grant_d;
            rd_addr_q    <= rd_addr_d;
            rd_src_q     <= rd_src_d;
            slot1_q      <= slot1_d;
            slot2_q      <= slot2_d;
            slot_valid_q <= slot_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    // Grant and completion pulses live in the strobe cycle; reset suppresses them.
    always_comb begin
        req_ready   = rst ? 2'b00 : ready_c;
        rsp_valid   = rst ? 1'b0 : rsp_valid_c;
        rsp_timeout = rst ? 1'b0 : rsp_timeout_c;
        rsp_data    = rst ? 16'h0000 : rsp_data_c;
        rsp_src     = rst ? 1'b0 : rsp_src_c;
    end

    assign ac97_out_slot1       = slot1_q;
    assign ac97_out_slot2       = slot2_q;
    assign ac97_out_slot1_valid = slot_valid_q;
    assign ac97_out_slot2_valid = slot_valid_q;
    assign init_done            = init_done_q;

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// tb/tb_ac97_cmd_sched.sv - self-checking bench for ac97_cmd_sched
module tb_ac97_cmd_sched;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ac97_strobe = 1'b0;
    logic [19:0] ac97_in_slot1 = '0;
    logic        ac97_in_slot1_valid = 1'b0;
    logic [19:0] ac97_in_slot2 = '0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [23:0] req_cmd0 = '0;
    logic [23:0] req_cmd1 = '0;
    logic [19:0] ac97_out_slot1;
    logic        ac97_out_slot1_valid;
    logic [19:0] ac97_out_slot2;
    logic        ac97_out_slot2_valid;
    logic        rsp_valid;
    logic        rsp_src;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        init_done;

    ac97_cmd_sched #(.TIMEOUT_FRAMES(TMO)) dut (
        .ac97_bitclk         (clk),
        .rst                 (rst),
        .ac97_strobe         (ac97_strobe),
        .ac97_in_slot1       (ac97_in_slot1),
        .ac97_in_slot1_valid (ac97_in_slot1_valid),
        .ac97_in_slot2       (ac97_in_slot2),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_cmd0            (req_cmd0),
        .req_cmd1            (req_cmd1),
        .ac97_out_slot1      (ac97_out_slot1),
        .ac97_out_slot1_valid(ac97_out_slot1_valid),
        .ac97_out_slot2      (ac97_out_slot2),
        .ac97_out_slot2_valid(ac97_out_slot2_valid),
        .rsp_valid           (rsp_valid),
        .rsp_src             (rsp_src),
        .rsp_data            (rsp_data),
        .rsp_timeout         (rsp_timeout),
        .init_done           (init_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Values captured in the strobe cycle (pulses) and just after it (slots).
    logic [1:0]  c_ready;
    logic        c_rv, c_src, c_tmo, c_v1, c_v2, c_id;
    logic [15:0] c_data;
    logic [19:0] c_s1, c_s2;

    // Entered and left at posedge+1; strobe cycle followed by gap idle cycles.
    task automatic strobe(input int gap);
        ac97_strobe = 1'b1;
        #2;
        c_ready = req_ready;
        c_rv    = rsp_valid;
        c_src   = rsp_src;
        c_data  = rsp_data;
        c_tmo   = rsp_timeout;
        @(posedge clk);
        #1;
        ac97_strobe = 1'b0;
        c_s1 = ac97_out_slot1;
        c_s2 = ac97_out_slot2;
        c_v1 = ac97_out_slot1_valid;
        c_v2 = ac97_out_slot2_valid;
        c_id = init_done;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
            chk("hold_slot1", ac97_out_slot1, c_s1);
            chk("hold_slot2", ac97_out_slot2, c_s2);
            chk("hold_valid", {ac97_out_slot1_valid, ac97_out_slot2_valid}, {c_v1, c_v2});
            chk("idle_pulses", {req_ready, rsp_valid}, 3'b000);
        end
    endtask

    // Reference model: counts strobes since reset and tracks the open read by issue frame.
    int          m_n, m_issue;
    logic        m_pend, m_last, m_src;
    logic [6:0]  m_addr;
    logic [19:0] init_s1 [4] = '{20'h00000, 20'h02000, 20'h04000, 20'h18000};
    logic [19:0] init_s2 [4] = '{20'h00000, 20'h00000, 20'h1F1F0, 20'h08080};
    logic [1:0]  e_ready;
    logic        e_rv, e_src, e_tmo, e_v, e_id;
    logic [15:0] e_data;
    logic [19:0] e_s1, e_s2;

    task automatic model_reset();
        m_n = 0; m_pend = 1'b0; m_last = 1'b1; m_issue = 0; m_addr = '0; m_src = 1'b0;
    endtask

    task automatic model_strobe();
        logic        g;
        logic [23:0] c;
        e_ready = 2'b00; e_rv = 0; e_src = 0; e_tmo = 0; e_data = 0;
        e_s1 = 0; e_s2 = 0; e_v = 0;
        m_n++;
        if (m_n <= 4) begin
            e_s1 = init_s1[m_n-1]; e_s2 = init_s2[m_n-1]; e_v = 1;
        end else if (m_n == 5) begin
            e_v = 0;
        end else if (m_pend) begin
            if (ac97_in_slot1_valid && ac97_in_slot1[18:12] == m_addr) begin
                e_rv = 1; e_src = m_src; e_data = ac97_in_slot2[19:4]; m_pend = 0;
            end else if (m_n - m_issue == TMO) begin
                e_rv = 1; e_src = m_src; e_data = 16'hFFFF; e_tmo = 1; m_pend = 0;
            end
        end else if (req_valid != 2'b00) begin
            g = (req_valid == 2'b11) ? !m_last : req_valid[1];
            c = g ? req_cmd1 : req_cmd0;
            m_last = g;
            e_ready = g ? 2'b10 : 2'b01;
            e_v = 1;
            e_s1 = {c[23], c[22:16], 12'h000};
            e_s2 = c[23] ? 20'h0 : {c[15:0], 4'h0};
            if (c[23]) begin
                m_pend = 1; m_issue = m_n; m_addr = c[22:16]; m_src = g;
            end
        end
        e_id = (m_n >= 5);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_ready"}, c_ready, e_ready);
        chk({tag, "_rsp_valid"}, c_rv, e_rv);
        if (e_rv) begin
            chk({tag, "_rsp_src"}, c_src, e_src);
            chk({tag, "_rsp_data"}, c_data, e_data);
            chk({tag, "_rsp_timeout"}, c_tmo, e_tmo);
        end
        chk({tag, "_slot1"}, c_s1, e_s1);
        chk({tag, "_slot2"}, c_s2, e_s2);
        chk({tag, "_valids"}, {c_v1, c_v2}, {e_v, e_v});
        chk({tag, "_init_done"}, c_id, e_id);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ac97_strobe = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic [23:0] c0, c1;
        logic        iv;
        logic [19:0] is1, is2;
        logic [1:0]  rdy;
        logic        rsp, src;
        logic [15:0] data;
        logic        tmo;
        logic [19:0] s1, s2;
        logic        v, id;
    } vec_t;

    function automatic vec_t mk(logic [1:0] rv, logic [23:0] c0, logic [23:0] c1, logic iv,
                                logic [19:0] is1, logic [19:0] is2, logic [1:0] rdy, logic rsp,
                                logic src, logic [15:0] data, logic tmo, logic [19:0] s1,
                                logic [19:0] s2, logic v, logic id);
        vec_t t;
        t.rv = rv; t.c0 = c0; t.c1 = c1; t.iv = iv; t.is1 = is1; t.is2 = is2;
        t.rdy = rdy; t.rsp = rsp; t.src = src; t.data = data; t.tmo = tmo;
        t.s1 = s1; t.s2 = s2; t.v = v; t.id = id;
        return t;
    endfunction

    vec_t tbl [18];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r0v, r1v;
        logic [23:0] rc0, rc1;
        logic [6:0]  a;
        int          sel;

        // Init, simultaneous writes, read with reply, read with timeout.
        tbl[0]  = mk(2'b00, 24'h0, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 1, 0);
        tbl[1]  = mk(2'b00, 24'h0, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h02000, 20'h00000, 1, 0);
        tbl[2]  = mk(2'b00, 24'h0, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h04000, 20'h1F1F0, 1, 0);
        tbl[3]  = mk(2'b00, 24'h0, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h18000, 20'h08080, 1, 0);
        tbl[4]  = mk(2'b00, 24'h0, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 0, 1);
        tbl[5]  = mk(2'b11, 24'h028000, 24'h180000, 0, 20'h0, 20'h0, 2'b01, 0, 0, 16'h0, 0, 20'h02000, 20'h80000, 1, 1);
        tbl[6]  = mk(2'b10, 24'h0, 24'h180000, 0, 20'h0, 20'h0, 2'b10, 0, 0, 16'h0, 0, 20'h18000, 20'h00000, 1, 1);
        tbl[7]  = mk(2'b10, 24'h0, 24'hA60000, 0, 20'h0, 20'h0, 2'b10, 0, 0, 16'h0, 0, 20'hA6000, 20'h00000, 1, 1);
        tbl[8]  = mk(2'b01, 24'h041234, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 0, 1);
        tbl[9]  = mk(2'b01, 24'h041234, 24'h0, 1, 20'h26000, 20'h000F0, 2'b00, 1, 1, 16'h000F, 0, 20'h00000, 20'h00000, 0, 1);
        tbl[10] = mk(2'b01, 24'h041234, 24'h0, 0, 20'h0, 20'h0, 2'b01, 0, 0, 16'h0, 0, 20'h04000, 20'h12340, 1, 1);
        tbl[11] = mk(2'b01, 24'hFC0000, 24'h0, 0, 20'h0, 20'h0, 2'b01, 0, 0, 16'h0, 0, 20'hFC000, 20'h00000, 1, 1);
        tbl[12] = mk(2'b10, 24'h0, 24'h180808, 1, 20'h26000, 20'h12340, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 0, 1);
        tbl[13] = mk(2'b10, 24'h0, 24'h180808, 1, 20'h26000, 20'h12340, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 0, 1);
        tbl[14] = mk(2'b10, 24'h0, 24'h180808, 1, 20'h26000, 20'h12340, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 0, 1);
        tbl[15] = mk(2'b10, 24'h0, 24'h180808, 1, 20'h26000, 20'h12340, 2'b00, 1, 0, 16'hFFFF, 1, 20'h00000, 20'h00000, 0, 1);
        tbl[16] = mk(2'b10, 24'h0, 24'h180808, 0, 20'h0, 20'h0, 2'b10, 0, 0, 16'h0, 0, 20'h18000, 20'h08080, 1, 1);
        tbl[17] = mk(2'b00, 24'h0, 24'h0, 0, 20'h0, 20'h0, 2'b00, 0, 0, 16'h0, 0, 20'h00000, 20'h00000, 0, 1);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_slots", {ac97_out_slot1, ac97_out_slot2}, 40'h0);
        chk("rst_valids", {ac97_out_slot1_valid, ac97_out_slot2_valid}, 2'b00);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_pulses", {req_ready, rsp_valid, rsp_timeout}, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            req_valid = tbl[i].rv; req_cmd0 = tbl[i].c0; req_cmd1 = tbl[i].c1;
            ac97_in_slot1_valid = tbl[i].iv; ac97_in_slot1 = tbl[i].is1; ac97_in_slot2 = tbl[i].is2;
            strobe(255);
            chk($sformatf("vec%0d_ready", i), c_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_rsp_valid", i), c_rv, tbl[i].rsp);
            chk($sformatf("vec%0d_rsp", i), {c_src, c_data, c_tmo}, {tbl[i].src, tbl[i].data, tbl[i].tmo});
            chk($sformatf("vec%0d_slot1", i), c_s1, tbl[i].s1);
            chk($sformatf("vec%0d_slot2", i), c_s2, tbl[i].s2);
            chk($sformatf("vec%0d_valids", i), {c_v1, c_v2}, {tbl[i].v, tbl[i].v});
            chk($sformatf("vec%0d_init_done", i), c_id, tbl[i].id);
        end

        // Reset during an outstanding read, coinciding with a matching reply.
        req_valid = 2'b01; req_cmd0 = 24'h900000;
        ac97_in_slot1_valid = 1'b0;
        strobe(255);
        chk("rdrst_issue_ready", c_ready, 2'b01);
        chk("rdrst_issue_slot1", c_s1, 20'h90000);
        req_valid = 2'b00;
        ac97_in_slot1_valid = 1'b1; ac97_in_slot1 = 20'h10000; ac97_in_slot2 = 20'hABCD0;
        rst = 1'b1;
        ac97_strobe = 1'b1;
        #2;
        chk("rdrst_no_rsp", {rsp_valid, req_ready}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ac97_strobe = 1'b0;
        chk("rdrst_init_done", init_done, 1'b0);
        chk("rdrst_valids", {ac97_out_slot1_valid, ac97_out_slot2_valid}, 2'b00);
        for (int i = 0; i < 5; i++) begin
            strobe(255);
            chk("rdrst_replay_rsp", c_rv, 1'b0);
            chk("rdrst_replay_slot1", c_s1, (i < 4) ? init_s1[i] : 20'h0);
            chk("rdrst_replay_slot2", c_s2, (i < 4) ? init_s2[i] : 20'h0);
            chk("rdrst_replay_valid", c_v1, (i < 4) ? 1'b1 : 1'b0);
            chk("rdrst_replay_init_done", c_id, (i < 4) ? 1'b0 : 1'b1);
        end

        // Randomized traffic against the reference model.
        ac97_in_slot1_valid = 1'b0;
        do_reset();
        r0v = 0; r1v = 0; rc0 = '0; rc1 = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                r0v = 0; r1v = 0;
            end
            if (!r0v && $urandom_range(0, 2) == 0) begin r0v = 1; rc0 = 24'($urandom); end
            if (!r1v && $urandom_range(0, 2) == 0) begin r1v = 1; rc1 = 24'($urandom); end
            req_valid = {r1v, r0v}; req_cmd0 = rc0; req_cmd1 = rc1;
            sel = int'($urandom_range(0, 3));
            a = m_pend ? m_addr : 7'($urandom);
            if (sel == 1) a = a ^ 7'($urandom_range(1, 127));
            ac97_in_slot1_valid = (sel < 2);
            ac97_in_slot1 = {1'($urandom), a, 12'($urandom)};
            ac97_in_slot2 = 20'($urandom);
            model_strobe();
            strobe(int'($urandom_range(0, 3)));
            compare_all("rnd");
            if (e_ready[0]) r0v = 0;
            if (e_ready[1]) r1v = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
